hood_mode_scheduler: RTL
========================

HOOD_MODE_SCHEDULER -- requirements
Module: hood_mode_scheduler

Interface
REQ-001 SHALL have parameter HURRICANE_SEC, default 60: hurricane run length in seconds (1..3599).
REQ-002 SHALL have parameter DRAIN_SEC, default 60: delayed-off length after standby is requested from hurricane (1..3599).
REQ-003 SHALL have parameter CLEAN_SEC, default 180: self-clean length in seconds (1..3599).
REQ-004 clk_1hz  input  1  scheduler clock; one cycle equals one second.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 req_standby, req_l1, req_l2, req_l3, req_clean  input  1 each  debounced level requests, sampled on the rising edge of clk_1hz.
REQ-007 mode_state  output  3  registered mode: 000 standby, 001 level1, 010 level2, 011 hurricane, 100 clean, 101 drain.
REQ-008 cd_min, cd_sec  output  6 each  registered countdown remaining (mm:ss); 0 when not in a timed state.
REQ-009 cum_min, cum_sec  output  6 each  registered cumulative fan run time (mm:ss).
REQ-010 hurricane_used  output  1  high once hurricane has been entered since reset.
REQ-011 clean_done  output  1  one-cycle pulse when self-clean completes.

Function
REQ-012 Simultaneous requests SHALL resolve by priority: req_standby > req_clean > req_l3 > req_l2 > req_l1; only the winner is evaluated, and an ignored winner does not pass to a lower request.
REQ-013 STANDBY: req_clean -> CLEAN; req_l3 -> HURRICANE only if hurricane_used=0, else no change; req_l2 -> LEVEL2; req_l1 -> LEVEL1.
REQ-014 LEVEL1/LEVEL2: req_standby -> STANDBY; req_l3 -> HURRICANE if hurricane_used=0; req_l1/req_l2 -> the requested level; req_clean SHALL be ignored.
REQ-015 HURRICANE: req_standby -> DRAIN; all other requests SHALL be ignored; countdown expiry -> LEVEL2.
REQ-016 DRAIN and CLEAN: all requests SHALL be ignored; expiry -> STANDBY.
REQ-017 On entry to a timed state the countdown SHALL load N/60 : N%60 for that state's N, on the same edge mode_state changes.
REQ-018 Each subsequent edge in a timed state SHALL decrement mm:ss by one second, borrowing (m:00 -> (m-1):59).
REQ-019 On the edge where remaining is 00:01, the state SHALL take its expiry transition and the countdown SHALL become 00:00; a timed state therefore lasts exactly N cycles.
REQ-020 hurricane_used SHALL set on the edge entering HURRICANE and clear only on reset.
REQ-021 Cumulative time SHALL increment by one second on every edge on which the pre-edge state is LEVEL1, LEVEL2 or HURRICANE; 59:59 SHALL wrap to 00:00.
REQ-022 On CLEAN expiry, clean_done SHALL pulse for exactly one cycle and cumulative time SHALL clear to 00:00 on the same edge, taking precedence over any increment.
REQ-023 Undefined state encodings SHALL recover to STANDBY on the next edge.

Reset
REQ-024 While rst=0: mode_state=000, cd_min=cd_sec=0, cum_min=cum_sec=0, hurricane_used=0, clean_done=0, regardless of clock.
REQ-025 Reset asserted mid-countdown SHALL abort the countdown; the first edge after release SHALL be evaluated from STANDBY.

Structure
REQ-026 Mode encodings and default durations SHALL live in shared package hood_pkg, reused by the display and lighting blocks.
REQ-027 A single sub-module mmss_down_counter (load, decrement, zero flag) SHALL implement the countdown.

Verification
REQ-028 Reset, then req_l3 held 1 cycle -> mode 011, cd 01:00, hurricane_used=1; 60 cycles later mode 010, cd 00:00, cum 01:00.
REQ-029 After REQ-028, from standby assert req_l3 -> mode stays 000; assert req_l3 and req_l1 together -> mode stays 000.
REQ-030 In hurricane at cd 00:30, assert req_standby -> mode 101, cd 01:00; req_l1 during drain ignored; 60 cycles later mode 000.
REQ-031 Preload cum 59:59 in level1, one edge -> cum 00:00; then standby, req_clean -> mode 100, cd 03:00; 180 cycles later mode 000, clean_done pulses once, cum 00:00.
REQ-032 Assert rst low in clean at cd 01:10 -> all outputs reset immediately; after release, req_l2 -> mode 010, cd 00:00.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared hood definitions: mode encodings and default timed-state durations.
// Reused by the scheduler, display and lighting blocks.
package hood_pkg;

   typedef enum logic [2:0] {
      MODE_STANDBY   = 3'b000,
      MODE_LEVEL1    = 3'b001,
      MODE_LEVEL2    = 3'b010,
      MODE_HURRICANE = 3'b011,
      MODE_CLEAN     = 3'b100,
      MODE_DRAIN     = 3'b101
   } mode_e;

   localparam int unsigned DEF_HURRICANE_SEC = 60;
   localparam int unsigned DEF_DRAIN_SEC     = 60;
   localparam int unsigned DEF_CLEAN_SEC     = 180;

   function automatic logic is_timed(input mode_e m);
      return (m == MODE_HURRICANE) || (m == MODE_DRAIN) || (m == MODE_CLEAN);
   endfunction

   function automatic logic is_running(input mode_e m);
      return (m == MODE_LEVEL1) || (m == MODE_LEVEL2) || (m == MODE_HURRICANE);
   endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// mm:ss countdown register with load, decrement-with-borrow, zero and
// last-second flags.
module mmss_down_counter (
   input  logic       clk_1hz,
   input  logic       rst,
   input  logic       load_i,
   input  logic [5:0] load_min_i,
   input  logic [5:0] load_sec_i,
   input  logic       dec_i,
   output logic [5:0] min_o,
   output logic [5:0] sec_o,
   output logic       zero_o,
   output logic       last_o
);

   logic [5:0] min_q, sec_q;

   always_ff @(posedge clk_1hz or negedge rst) begin
      if (!rst) begin
         min_q <= '0;
         sec_q <= '0;
      end else if (load_i) begin
         min_q <= load_min_i;
         sec_q <= load_sec_i;
      end else if (dec_i && !zero_o) begin
         if (sec_q == 6'd0) begin
            min_q <= min_q - 6'd1;
            sec_q <= 6'd59;
         end else begin
            sec_q <= sec_q - 6'd1;
         end
      end
   end

   assign min_o  = min_q;
   assign sec_o  = sec_q;
   assign zero_o = (min_q == 6'd0) && (sec_q == 6'd0);
   assign last_o = (min_q == 6'd0) && (sec_q == 6'd1);

endmodule

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode scheduler: prioritised request handling, timed states
// with mm:ss countdown, cumulative fan run time and self-clean pulse.
module hood_mode_scheduler
   import hood_pkg::*;
#(
   parameter int unsigned HURRICANE_SEC = DEF_HURRICANE_SEC,
   parameter int unsigned DRAIN_SEC     = DEF_DRAIN_SEC,
   parameter int unsigned CLEAN_SEC     = DEF_CLEAN_SEC
) (
   input  logic       clk_1hz,
   input  logic       rst,
   input  logic       req_standby,
   input  logic       req_l1,
   input  logic       req_l2,
   input  logic       req_l3,
   input  logic       req_clean,
   output logic [2:0] mode_state,
   output logic [5:0] cd_min,
   output logic [5:0] cd_sec,
   output logic [5:0] cum_min,
   output logic [5:0] cum_sec,
   output logic       hurricane_used,
   output logic       clean_done
);

   localparam logic [5:0] H_MIN = 6'(HURRICANE_SEC / 60);
   localparam logic [5:0] H_SEC = 6'(HURRICANE_SEC % 60);
   localparam logic [5:0] D_MIN = 6'(DRAIN_SEC / 60);
   localparam logic [5:0] D_SEC = 6'(DRAIN_SEC % 60);
   localparam logic [5:0] C_MIN = 6'(CLEAN_SEC / 60);
   localparam logic [5:0] C_SEC = 6'(CLEAN_SEC % 60);

   mode_e      state_q, state_d;
   logic       used_q, done_q;
   logic [5:0] cum_min_q, cum_sec_q;
   logic       cd_zero, cd_last;
   logic       cnt_load, cnt_dec;
   logic [5:0] ld_min, ld_sec;

   // Only the highest-priority active request is evaluated; if it is
   // ignored in the current mode, lower requests do not get a turn.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MODE_STANDBY: begin
            if (req_standby)    state_d = MODE_STANDBY;
            else if (req_clean) state_d = MODE_CLEAN;
            else if (req_l3)    state_d = used_q ? MODE_STANDBY : MODE_HURRICANE;
            else if (req_l2)    state_d = MODE_LEVEL2;
            else if (req_l1)    state_d = MODE_LEVEL1;
         end
         MODE_LEVEL1, MODE_LEVEL2: begin
            if (req_standby)    state_d = MODE_STANDBY;
            else if (req_clean) state_d = state_q;
            else if (req_l3)    state_d = used_q ? state_q : MODE_HURRICANE;
            else if (req_l2)    state_d = MODE_LEVEL2;
            else if (req_l1)    state_d = MODE_LEVEL1;
         end
         MODE_HURRICANE: begin
            if (cd_last)          state_d = MODE_LEVEL2;
            else if (req_standby) state_d = MODE_DRAIN;
         end
         MODE_DRAIN, MODE_CLEAN: begin
            if (cd_last) state_d = MODE_STANDBY;
         end
         default: state_d = MODE_STANDBY;
      endcase
   end

   // Any edge whose next state is untimed forces the countdown to 00:00.
   always_comb begin
      ld_min   = '0;
      ld_sec   = '0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (!is_timed(state_d)) begin
         cnt_load = 1'b1;
      end else if (state_d != state_q) begin
         cnt_load = 1'b1;
         case (state_d)
            MODE_HURRICANE: begin ld_min = H_MIN; ld_sec = H_SEC; end
            MODE_DRAIN:     begin ld_min = D_MIN; ld_sec = D_SEC; end
            default:        begin ld_min = C_MIN; ld_sec = C_SEC; end
         endcase
      end else begin
         cnt_dec = !cd_zero;
      end
   end

   mmss_down_counter u_cd (
      .clk_1hz    (clk_1hz),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_min_i (ld_min),
      .load_sec_i (ld_sec),
      .dec_i      (cnt_dec),
      .min_o      (cd_min),
      .sec_o      (cd_sec),
      .zero_o     (cd_zero),
      .last_o     (cd_last)
   );

   always_ff @(posedge clk_1hz or negedge rst) begin
      if (!rst) begin
         state_q   <= MODE_STANDBY;
         used_q    <= 1'b0;
         done_q    <= 1'b0;
         cum_min_q <= '0;
         cum_sec_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == MODE_HURRICANE && state_q != MODE_HURRICANE)
            used_q <= 1'b1;
         done_q <= (state_q == MODE_CLEAN) && cd_last;
         if ((state_q == MODE_CLEAN) && cd_last) begin
            cum_min_q <= '0;
            cum_sec_q <= '0;
         end else if (is_running(state_q)) begin
            if (cum_sec_q == 6'd59) begin
               cum_sec_q <= '0;
               cum_min_q <= (cum_min_q == 6'd59) ? 6'd0 : cum_min_q + 6'd1;
            end else begin
               cum_sec_q <= cum_sec_q + 6'd1;
            end
         end
      end
   end

   assign mode_state     = state_q;
   assign hurricane_used = used_q;
   assign clean_done     = done_q;
   assign cum_min        = cum_min_q;
   assign cum_sec        = cum_sec_q;

endmodule
